mblk_scan_scheduler: RTL and testbench
======================================

# mblk_scan_scheduler

Frame-level scheduler for the macroblock processing engine. Given a frame size and a `teMacroBlockType`, it walks the frame in raster order. For each macroblock it issues one descriptor (pixel origin and size) to the engine through a valid/ready handshake, then waits for the engine's completion before issuing the next. It sits between the frame-control registers and the macroblock datapath, and is the sole sequencer of that datapath.

## Interface
- `DIM_W`, 12: width of frame dimension and origin fields, in pixels.
- `iClk`  in  1  system clock.
- `iRst_n`  in  1  asynchronous, active-low reset.
- `iStart`  in  1  frame start request; sampled only in IDLE.
- `iMblkType`  in  2  `teMacroBlockType`, latched at start.
- `iFrameW`, `iFrameH`  in  DIM_W  frame size in pixels, latched at start.
- `oBusy`  out  1  high from the accepted start through the DONE cycle.
- `oCmdValid`  out  1  descriptor valid.
- `iCmdReady`  in  1  engine accepts the descriptor.
- `oCmdX`, `oCmdY`  out  DIM_W  pixel origin of the block.
- `oCmdW`, `oCmdH`  out  7  block width and height, 1..64.
- `oCmdLast`  out  1  this is the final block of the frame.
- `iBlkDone`  in  1  one-cycle pulse: the engine has finished the accepted block.
- `oFrameDone`  out  1  one-cycle pulse when the frame completes.
- `oErr`  out  1  one-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE → ISSUE:** taken when `iStart` is high and the start is valid (type is not 2'b00, W≠0, H≠0, plus the size check under Configuration).
  - On this transition, latch type, W and H, and set X = Y = 0.
  - An invalid start pulses `oErr` for one cycle and the block stays in IDLE.
- **ISSUE:** `oCmdValid` = 1. When `iCmdReady` is high, go to WAIT. Descriptor fields stay stable while valid and not ready.
- **WAIT:** on `iBlkDone`:
  - if `oCmdLast` was set, go to DONE;
  - otherwise advance and go to ISSUE.
- **DONE:** `oFrameDone` = 1 for one cycle, then go to IDLE.
- **Block size S:** 64, 32 or 16 for types 01, 10 and 11 respectively.
- **Advance (raster order):**
  - X += S.
  - If the new X ≥ last column limit, set X = 0 and Y += S.
  - Limits are computed at DIM_W+1 bits, so there is no overflow at the frame edge.
- **Outstanding blocks:** at most one. Only one block is in flight at a time.
- **Ignored inputs:** `iStart` outside IDLE; `iBlkDone` outside WAIT.
- **Reset (async assert, any state):**
  - state returns to IDLE;
  - every output goes to 0, including the `oCmdW`/`oCmdH` registers;
  - in-flight blocks are abandoned.

## Timing
- All outputs are registered.
- A start accepted in cycle N gives `oCmdValid` = 1 in cycle N+1.
- A handshake in cycle N (valid & ready) gives `oCmdValid` = 0 in cycle N+1.
- `iBlkDone` in cycle N gives either the next `oCmdValid` or `oFrameDone` in cycle N+1.
- `oErr` is asserted in the cycle after the rejected `iStart`.
- `oBusy` = 1 from N+1 through the DONE cycle inclusive.

## Configuration
- **Macro:** `MBLK_SCHED_PARTIAL_EN`.
- **Defined:** the column count is ceil(W/S) and the row count is ceil(H/S).
  - Edge blocks carry `oCmdW` = W−X and/or `oCmdH` = H−Y when the remainder is less than S.
  - Any W, H ≥ 1 is valid.
- **Undefined:** the column count is floor(W/S) and the row count is floor(H/S).
  - Remainder pixels are never issued.
  - `oCmdW` = `oCmdH` = S always.
  - A start with W < S or H < S is invalid and triggers `oErr`.

## Structure
- Add to package `tPImageProcessing`:
  - constants `MBLK_SIZE_64`, `MBLK_SIZE_32`, `MBLK_SIZE_16`;
  - function `fMblkSize(teMacroBlockType)` returning S (0 for 2'b00);
  - typedef `tsMblkCmd` holding the x, y, w, h and last fields;
  - typedef `teMblkSchedState`.
- One sub-module, `mblk_edge_clip`:
  - combinational;
  - takes X, Y, W, H and S;
  - returns the clipped w/h, the end-of-row flag and the last-block flag.

## Test plan
- **64×64 full tiles:** type 01, W=128, H=64, engine always ready, `iBlkDone` 3 cycles after acceptance → descriptors (0,0), (64,0); `oCmdLast` on the second; `oFrameDone` 1 cycle after the second `iBlkDone`.
- **Edge clipping:** type 11, W=40, H=20.
  - With the macro: 6 blocks, the final one (32,16) has w=8, h=4.
  - Without the macro: 2 blocks, (0,0) and (16,0), each 16×16.
- **Backpressure:** type 10, `iCmdReady` held low for 5 cycles → `oCmdValid` and all fields stable for 5 cycles; one acceptance only.
- **Invalid start:** type 00, or W=0, or (without the macro) W=8 with type 11 → `oErr` pulse 1 cycle later, `oBusy` stays 0, no `oCmdValid`.
- **Spurious inputs:** `iStart` while busy and `iBlkDone` during ISSUE → ignored; block count unchanged.
- **Mid-frame reset:** `iRst_n` low during WAIT of block 2 → all outputs 0 immediately. After release, a fresh start begins at (0,0).

Source files
------------

// File: rtl/mblk_scan_scheduler_pkg.sv
// Shared types and helpers for the macroblock scan scheduler.
// Optional partial-edge support is selected with MBLK_SCHED_PARTIAL_EN.
package tPImageProcessing;

  localparam int MBLK_DIM_W = 12;

  localparam logic [6:0] MBLK_SIZE_64 = 7'd64;
  localparam logic [6:0] MBLK_SIZE_32 = 7'd32;
  localparam logic [6:0] MBLK_SIZE_16 = 7'd16;

  typedef enum logic [1:0] {
    MBLK_TYPE_NONE = 2'b00,
    MBLK_TYPE_64   = 2'b01,
    MBLK_TYPE_32   = 2'b10,
    MBLK_TYPE_16   = 2'b11
  } teMacroBlockType;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } teMblkSchedState;

  typedef struct packed {
    logic [MBLK_DIM_W-1:0] x;
    logic [MBLK_DIM_W-1:0] y;
    logic [6:0]            w;
    logic [6:0]            h;
    logic                  last;
  } tsMblkCmd;

  function automatic logic [6:0] fMblkSize(input teMacroBlockType t);
    case (t)
      MBLK_TYPE_64: fMblkSize = MBLK_SIZE_64;
      MBLK_TYPE_32: fMblkSize = MBLK_SIZE_32;
      MBLK_TYPE_16: fMblkSize = MBLK_SIZE_16;
      default:      fMblkSize = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/mblk_scan_scheduler_edge_clip.sv
// Combinational block geometry: clipped size, end-of-row and last-block flags.
// MBLK_SCHED_PARTIAL_EN enables partial edge blocks; otherwise remainders are dropped.
module mblk_edge_clip
  import tPImageProcessing::*;
#(
  parameter int DIM_W = MBLK_DIM_W
) (
  input  logic [DIM_W-1:0] iX,
  input  logic [DIM_W-1:0] iY,
  input  logic [DIM_W-1:0] iW,
  input  logic [DIM_W-1:0] iH,
  input  logic [6:0]       iS,
  output logic [6:0]       oW,
  output logic [6:0]       oH,
  output logic             oEndOfRow,
  output logic             oLast
);

  logic [DIM_W-1:0] pos   [2];
  logic [DIM_W-1:0] dim   [2];
  logic [6:0]       size  [2];
  logic             reach [2];
  logic [DIM_W:0]   s_ext;

  assign pos[0] = iX;
  assign pos[1] = iY;
  assign dim[0] = iW;
  assign dim[1] = iH;
  assign s_ext  = {{(DIM_W-6){1'b0}}, iS};

  // Axis 0 is the column direction, axis 1 the row direction; limits carry an extra bit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [DIM_W:0] lim;
    logic [DIM_W:0] pos_end;
`ifdef MBLK_SCHED_PARTIAL_EN
    logic [DIM_W:0] rem;
    assign lim      = {1'b0, dim[gi]};
    assign rem      = {1'b0, dim[gi]} - {1'b0, pos[gi]};
    assign size[gi] = (rem < s_ext) ? 7'(rem) : iS;
`else
    logic [DIM_W-1:0] mask;
    assign mask     = ~({{(DIM_W-7){1'b0}}, iS - 7'd1});
    assign lim      = {1'b0, dim[gi] & mask};
    assign size[gi] = iS;
`endif
    assign pos_end   = {1'b0, pos[gi]} + s_ext;
    assign reach[gi] = (pos_end >= lim);
  end

  assign oW        = size[0];
  assign oH        = size[1];
  assign oEndOfRow = reach[0];
  assign oLast     = reach[0] & reach[1];

endmodule

// File: rtl/mblk_scan_scheduler.sv
// Raster-order macroblock scheduler: one descriptor in flight, valid/ready issue, done pulse.
// MBLK_SCHED_PARTIAL_EN (in mblk_edge_clip) allows clipped edge blocks and any nonzero size.
module mblk_scan_scheduler
  import tPImageProcessing::*;
#(
  parameter int DIM_W = MBLK_DIM_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [1:0]       iMblkType,
  input  logic [DIM_W-1:0] iFrameW,
  input  logic [DIM_W-1:0] iFrameH,
  output logic             oBusy,
  output logic             oCmdValid,
  input  logic             iCmdReady,
  output logic [DIM_W-1:0] oCmdX,
  output logic [DIM_W-1:0] oCmdY,
  output logic [6:0]       oCmdW,
  output logic [6:0]       oCmdH,
  output logic             oCmdLast,
  input  logic             iBlkDone,
  output logic             oFrameDone,
  output logic             oErr
);

  teMblkSchedState  state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [DIM_W-1:0] fw_q, fw_d, fh_q, fh_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [6:0]       cmd_w_q, cmd_w_d, cmd_h_q, cmd_h_d;
  logic             last_q, last_d, eor_q, eor_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic             fdone_q, fdone_d, err_q, err_d;

  logic [6:0]       s_cur, s_req;
  logic [DIM_W-1:0] s_cur_ext, s_req_ext;
  logic             start_ok;

  logic [DIM_W-1:0] clip_x, clip_y, clip_fw, clip_fh;
  logic [6:0]       clip_s, clip_cw, clip_ch;
  logic             clip_eor, clip_last;

  assign s_cur     = fMblkSize(teMacroBlockType'(type_q));
  assign s_req     = fMblkSize(teMacroBlockType'(iMblkType));
  assign s_cur_ext = {{(DIM_W-7){1'b0}}, s_cur};
  assign s_req_ext = {{(DIM_W-7){1'b0}}, s_req};

`ifdef MBLK_SCHED_PARTIAL_EN
  assign start_ok = (iMblkType != 2'b00) && (iFrameW != '0) && (iFrameH != '0);
`else
  assign start_ok = (iMblkType != 2'b00) && (iFrameW >= s_req_ext) && (iFrameH >= s_req_ext);
`endif

  // The clipper always evaluates the block about to be issued: origin in IDLE, else the next raster step.
  always_comb begin
    if (state_q == ST_IDLE) begin
      clip_x  = '0;
      clip_y  = '0;
      clip_fw = iFrameW;
      clip_fh = iFrameH;
      clip_s  = s_req;
    end else begin
      clip_x  = eor_q ? '0 : x_q + s_cur_ext;
      clip_y  = eor_q ? y_q + s_cur_ext : y_q;
      clip_fw = fw_q;
      clip_fh = fh_q;
      clip_s  = s_cur;
    end
  end

  mblk_edge_clip #(
    .DIM_W(DIM_W)
  ) u_edge_clip (
    .iX        (clip_x),
    .iY        (clip_y),
    .iW        (clip_fw),
    .iH        (clip_fh),
    .iS        (clip_s),
    .oW        (clip_cw),
    .oH        (clip_ch),
    .oEndOfRow (clip_eor),
    .oLast     (clip_last)
  );

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    fw_d    = fw_q;
    fh_d    = fh_q;
    x_d     = x_q;
    y_d     = y_q;
    cmd_w_d = cmd_w_q;
    cmd_h_d = cmd_h_q;
    last_d  = last_q;
    eor_d   = eor_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    fdone_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          if (start_ok) begin
            type_d  = iMblkType;
            fw_d    = iFrameW;
            fh_d    = iFrameH;
            x_d     = '0;
            y_d     = '0;
            cmd_w_d = clip_cw;
            cmd_h_d = clip_ch;
            last_d  = clip_last;
            eor_d   = clip_eor;
            busy_d  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (iCmdReady) begin
          valid_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (iBlkDone) begin
          if (last_q) begin
            fdone_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            x_d     = clip_x;
            y_d     = clip_y;
            cmd_w_d = clip_cw;
            cmd_h_d = clip_ch;
            last_d  = clip_last;
            eor_d   = clip_eor;
            valid_d = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      fw_q    <= '0;
      fh_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cmd_w_q <= '0;
      cmd_h_q <= '0;
      last_q  <= 1'b0;
      eor_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      fw_q    <= fw_d;
      fh_q    <= fh_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cmd_w_q <= cmd_w_d;
      cmd_h_q <= cmd_h_d;
      last_q  <= last_d;
      eor_q   <= eor_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
    end
  end

  assign oBusy      = busy_q;
  assign oCmdValid  = valid_q;
  assign oCmdX      = x_q;
  assign oCmdY      = y_q;
  assign oCmdW      = cmd_w_q;
  assign oCmdH      = cmd_h_q;
  assign oCmdLast   = last_q;
  assign oFrameDone = fdone_q;
  assign oErr       = err_q;

endmodule

// File: tb/tb_mblk_scan_scheduler.sv
// Randomized bench for mblk_scan_scheduler against a tile-list reference model.
// Honours MBLK_SCHED_PARTIAL_EN the same way as the design.
module tb_mblk_scan_scheduler;
  import tPImageProcessing::*;

  localparam int DIM_W = 12;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iStart = 1'b0;
  logic [1:0]       iMblkType = 2'b00;
  logic [DIM_W-1:0] iFrameW = '0;
  logic [DIM_W-1:0] iFrameH = '0;
  logic             iCmdReady = 1'b0;
  logic             iBlkDone = 1'b0;
  logic             oBusy, oCmdValid, oCmdLast, oFrameDone, oErr;
  logic [DIM_W-1:0] oCmdX, oCmdY;
  logic [6:0]       oCmdW, oCmdH;

  int checks = 0;
  int errors = 0;
  tsMblkCmd exp_q[$];

  mblk_scan_scheduler #(.DIM_W(DIM_W)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iStart     (iStart),
    .iMblkType  (iMblkType),
    .iFrameW    (iFrameW),
    .iFrameH    (iFrameH),
    .oBusy      (oBusy),
    .oCmdValid  (oCmdValid),
    .iCmdReady  (iCmdReady),
    .oCmdX      (oCmdX),
    .oCmdY      (oCmdY),
    .oCmdW      (oCmdW),
    .oCmdH      (oCmdH),
    .oCmdLast   (oCmdLast),
    .iBlkDone   (iBlkDone),
    .oFrameDone (oFrameDone),
    .oErr       (oErr)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int size_of(input int t);
    return (t == 1) ? 64 : (t == 2) ? 32 : 16;
  endfunction

  // Expected descriptor list: a plain tile grid over the frame.
  task automatic build_exp(input int t, input int w, input int h);
    int s, cols, rows;
    tsMblkCmd c;
    s = size_of(t);
`ifdef MBLK_SCHED_PARTIAL_EN
    cols = (w + s - 1) / s;
    rows = (h + s - 1) / s;
`else
    cols = w / s;
    rows = h / s;
`endif
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int k = 0; k < cols; k++) begin
        c.x    = 12'(k * s);
        c.y    = 12'(r * s);
        c.w    = 7'((w - k * s < s) ? (w - k * s) : s);
        c.h    = 7'((h - r * s < s) ? (h - r * s) : s);
        c.last = (r == rows - 1) && (k == cols - 1);
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic check_desc(input string tag, input tsMblkCmd e);
    check({tag, "_x"}, 32'(oCmdX), 32'(e.x));
    check({tag, "_y"}, 32'(oCmdY), 32'(e.y));
    check({tag, "_w"}, 32'(oCmdW), 32'(e.w));
    check({tag, "_h"}, 32'(oCmdH), 32'(e.h));
    check({tag, "_last"}, 32'(oCmdLast), 32'(e.last));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(oCmdValid), 0);
    check({tag, "_busy"}, 32'(oBusy), 0);
    check({tag, "_x"}, 32'(oCmdX), 0);
    check({tag, "_y"}, 32'(oCmdY), 0);
    check({tag, "_w"}, 32'(oCmdW), 0);
    check({tag, "_h"}, 32'(oCmdH), 0);
    check({tag, "_last"}, 32'(oCmdLast), 0);
    check({tag, "_fdone"}, 32'(oFrameDone), 0);
    check({tag, "_err"}, 32'(oErr), 0);
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic run_frame(input int t, input int w, input int h, input int rdy_dly, input int done_dly);
    int d;
    build_exp(t, w, h);
    $display("frame type=%0d W=%0d H=%0d blocks=%0d", t, w, h, exp_q.size());
    @(negedge iClk);
    iStart = 1'b1; iMblkType = 2'(t); iFrameW = 12'(w); iFrameH = 12'(h);
    @(negedge iClk);
    iStart = 1'b0;
    check("start_valid", 32'(oCmdValid), 1);
    check("start_busy", 32'(oBusy), 1);
    check("start_err", 32'(oErr), 0);
    foreach (exp_q[i]) begin
      d = (rdy_dly < 0) ? $urandom_range(0, 3) : rdy_dly;
      for (int k = 0; k < d; k++) begin
        check("hold_valid", 32'(oCmdValid), 1);
        check_desc("hold", exp_q[i]);
        iCmdReady = 1'b0;
        iBlkDone  = 1'($urandom_range(0, 1));
        @(negedge iClk);
        iBlkDone = 1'b0;
      end
      check("cmd_valid", 32'(oCmdValid), 1);
      check_desc("cmd", exp_q[i]);
      $display("blk %0d x=%0d y=%0d w=%0d h=%0d last=%0d", i, oCmdX, oCmdY, oCmdW, oCmdH, oCmdLast);
      iCmdReady = 1'b1;
      @(negedge iClk);
      iCmdReady = 1'b0;
      check("accept_drop", 32'(oCmdValid), 0);
      d = (done_dly < 0) ? $urandom_range(0, 4) : done_dly;
      for (int k = 0; k < d; k++) begin
        iStart    = 1'($urandom_range(0, 1));
        iMblkType = 2'($urandom);
        iFrameW   = 12'($urandom);
        iFrameH   = 12'($urandom);
        @(negedge iClk);
        iStart = 1'b0;
        check("wait_valid", 32'(oCmdValid), 0);
        check("wait_err", 32'(oErr), 0);
      end
      iBlkDone = 1'b1;
      @(negedge iClk);
      iBlkDone = 1'b0;
      if (exp_q[i].last) begin
        check("fdone", 32'(oFrameDone), 1);
        check("fdone_busy", 32'(oBusy), 1);
        check("fdone_valid", 32'(oCmdValid), 0);
      end else begin
        check("next_valid", 32'(oCmdValid), 1);
        check("next_fdone", 32'(oFrameDone), 0);
      end
    end
    @(negedge iClk);
    check("end_fdone", 32'(oFrameDone), 0);
    check("end_busy", 32'(oBusy), 0);
  endtask

  task automatic invalid_start(input string tag, input int t, input int w, input int h);
    $display("invalid start %s type=%0d W=%0d H=%0d", tag, t, w, h);
    @(negedge iClk);
    iStart = 1'b1; iMblkType = 2'(t); iFrameW = 12'(w); iFrameH = 12'(h);
    @(negedge iClk);
    iStart = 1'b0;
    check({tag, "_err"}, 32'(oErr), 1);
    check({tag, "_busy"}, 32'(oBusy), 0);
    check({tag, "_valid"}, 32'(oCmdValid), 0);
    @(negedge iClk);
    check({tag, "_err_clr"}, 32'(oErr), 0);
    check({tag, "_busy2"}, 32'(oBusy), 0);
    check({tag, "_valid2"}, 32'(oCmdValid), 0);
  endtask

  initial begin
    int t, s, w, h;
    repeat (2) @(negedge iClk);
    check_all_zero("reset");
    iRst_n = 1'b1;
    @(negedge iClk);

    run_frame(1, 128, 64, 0, 2);
    run_frame(3, 40, 20, -1, -1);
    run_frame(2, 64, 32, 5, 1);

    invalid_start("inv_type", 0, 64, 64);
    invalid_start("inv_w0", 1, 0, 64);
    invalid_start("inv_h0", 2, 64, 0);
`ifndef MBLK_SCHED_PARTIAL_EN
    invalid_start("inv_small", 3, 8, 64);
`else
    run_frame(3, 8, 64, -1, -1);
`endif

    for (int n = 0; n < 20; n++) begin
      t = $urandom_range(1, 3);
      s = size_of(t);
`ifdef MBLK_SCHED_PARTIAL_EN
      w = $urandom_range(1, 160);
      h = $urandom_range(1, 100);
`else
      w = $urandom_range(s, 160);
      h = $urandom_range(s, 100);
`endif
      run_frame(t, w, h, -1, -1);
    end

    // Reset asserted mid-frame, during the wait for block 2.
    $display("mid-frame reset");
    @(negedge iClk);
    iStart = 1'b1; iMblkType = 2'd1; iFrameW = 12'd128; iFrameH = 12'd128;
    @(negedge iClk);
    iStart = 1'b0; iCmdReady = 1'b1;
    @(negedge iClk);
    iCmdReady = 1'b0; iBlkDone = 1'b1;
    @(negedge iClk);
    iBlkDone = 1'b0; iCmdReady = 1'b1;
    check("mid_blk2_x", 32'(oCmdX), 64);
    @(negedge iClk);
    iCmdReady = 1'b0;
    #2 iRst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge iClk);
    iRst_n = 1'b1;
    run_frame(1, 128, 64, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
